// File: rtl/mc6809_pkg.sv
// Shared definitions for the mc6809 bus slave: address map constants, bus FSM states,
// and the region decode used to pick the read data source.
package mc6809_pkg;

    localparam logic [15:0] VEC_BASE = 16'hFFF0;
    localparam logic [7:0]  OP_NOP   = 8'h12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_HOLD
    } bus_state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_VEC,
        RGN_FILL
    } region_t;

    // RAM wins over the vector block, so a full 64K RAM hides the vectors.
    function automatic region_t region_of(input logic [15:0] a, input int unsigned aw);
        if ((a >> aw) == 16'd0)
            return RGN_RAM;
        else if (a >= VEC_BASE)
            return RGN_VEC;
        else
            return RGN_FILL;
    endfunction

endpackage

// File: rtl/mc6809_sync_ram.sv
// Byte-wide RAM with registered read data, one write and one read per clk.
// A read that hits the address being written in the same clk returns the new byte.
module mc6809_sync_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/mc6809_bus_slave.sv
// Memory slave for the mc6809: RAM, vector block and NOP fill; read data lands 2 clks after Q rises.
// Slow-window accesses pull MRDY low for WAIT_CLKS clks; BA=1 cycles are ignored.
module mc6809_bus_slave
    import mc6809_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [7:0]  FILL_BYTE = OP_NOP,
    parameter logic [15:0] SLOW_BASE = 16'h8000,
    parameter logic [15:0] SLOW_MASK = 16'hF000,
    parameter int          WAIT_CLKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DOut,
    input  logic        RnW,
    input  logic        E,
    input  logic        Q,
    input  logic        BA,
    output logic [7:0]  D,
    output logic        MRDY,
    output logic        wr_strobe,
    output logic [15:0] bus_cycles,
    output logic        bus_err
);

    localparam int CW = (WAIT_CLKS > 0) ? $clog2(WAIT_CLKS + 1) : 1;

    logic          e_d, q_d;
    logic          q_rise, e_fall;
    bus_state_t    state, state_nx;
    logic [15:0]   addr_q;
    logic          rnw_q;
    logic [7:0]    dout_q;
    logic [CW-1:0] wait_cnt;
    logic          slow_hit, wait_last;
    region_t       rgn;
    logic          start, commit, abort;
    logic          ram_we;
    logic [7:0]    ram_rdata, rd_sel;

    // Edge history keeps running through reset so a Q already high at release is not a new cycle.
    always_ff @(posedge clk) begin
        e_d <= E;
        q_d <= Q;
    end

    assign q_rise    = Q & ~q_d;
    assign e_fall    = ~E & e_d;
    assign rgn       = region_of(addr_q, RAM_AW);
    assign slow_hit  = (WAIT_CLKS > 0) && ((addr_q & SLOW_MASK) == SLOW_BASE);
    assign wait_last = (wait_cnt <= CW'(1));
    assign ram_we    = commit && !reset;

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (q_rise && !BA) state_nx = ST_DECODE;
            ST_DECODE: state_nx = slow_hit ? ST_WAIT : ST_HOLD;
            ST_WAIT:   if (wait_last) state_nx = ST_HOLD;
            ST_HOLD: begin
                if (q_rise)
                    state_nx = BA ? ST_IDLE : ST_DECODE;
                else if (e_fall)
                    state_nx = ST_IDLE;
            end
            default:   state_nx = ST_IDLE;
        endcase
    end

    // A Q rise in HOLD without E falling means the CPU restarted early; the write is lost.
    always_comb begin
        start  = 1'b0;
        commit = 1'b0;
        abort  = 1'b0;
        case (state)
            ST_IDLE: start = q_rise && !BA;
            ST_HOLD: begin
                start  = q_rise && !BA;
                abort  = q_rise && !e_fall;
                commit = e_fall && !rnw_q && (rgn == RGN_RAM);
            end
            default: ;
        endcase
    end

    always_comb begin
        case (rgn)
            RGN_RAM: rd_sel = ram_rdata;
            RGN_VEC: rd_sel = addr_q[0] ? RESET_VEC[7:0] : RESET_VEC[15:8];
            default: rd_sel = FILL_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            D          <= FILL_BYTE;
            MRDY       <= 1'b1;
            wr_strobe  <= 1'b0;
            bus_cycles <= 16'd0;
            bus_err    <= 1'b0;
            wait_cnt   <= '0;
            addr_q     <= 16'd0;
            rnw_q      <= 1'b1;
            dout_q     <= 8'd0;
        end else begin
            wr_strobe <= commit;
            if (abort)
                bus_err <= 1'b1;
            if (start) begin
                addr_q     <= ADDR;
                rnw_q      <= RnW;
                dout_q     <= DOut;
                bus_cycles <= bus_cycles + 16'd1;
            end
            if (state == ST_DECODE) begin
                if (rnw_q)
                    D <= rd_sel;
                if (slow_hit) begin
                    MRDY     <= 1'b0;
                    wait_cnt <= CW'(WAIT_CLKS);
                end
            end
            if (state == ST_WAIT) begin
                if (wait_last) begin
                    MRDY     <= 1'b1;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt - CW'(1);
                end
            end
        end
    end

    mc6809_sync_ram #(
        .AW(RAM_AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(addr_q[RAM_AW-1:0]),
        .wdata(dout_q),
        .re   (start),
        .raddr(ADDR[RAM_AW-1:0]),
        .rdata(ram_rdata)
    );

endmodule

// File: tb/tb_mc6809_bus_slave.sv
// Bench for mc6809_bus_slave: directed bus cycles then randomized ones, checked every clk
// against a timeline model of the slave kept in the bench.
module tb_mc6809_bus_slave;

    localparam logic [15:0] RV = 16'hE000;
    localparam int          W  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ADDR = 16'd0;
    logic [7:0]  DOut = 8'd0;
    logic        RnW = 1'b1;
    logic        E = 1'b0;
    logic        Q = 1'b0;
    logic        BA = 1'b0;
    logic [7:0]  D;
    logic        MRDY;
    logic        wr_strobe;
    logic [15:0] bus_cycles;
    logic        bus_err;

    always #5 clk = ~clk;

    mc6809_bus_slave #(
        .RAM_AW   (12),
        .RESET_VEC(RV),
        .FILL_BYTE(8'h12),
        .SLOW_BASE(16'h8000),
        .SLOW_MASK(16'hF000),
        .WAIT_CLKS(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ADDR      (ADDR),
        .DOut      (DOut),
        .RnW       (RnW),
        .E         (E),
        .Q         (Q),
        .BA        (BA),
        .D         (D),
        .MRDY      (MRDY),
        .wr_strobe (wr_strobe),
        .bus_cycles(bus_cycles),
        .bus_err   (bus_err)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;
    int low_cnt = 0;
    int wr_cnt = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted cycle is tracked by its age in clks since the Q-rise sample.
    logic [7:0]  mem_m [4096];
    bit          known_m [4096];
    logic [7:0]  exp_d = 8'h12;
    bit          exp_d_known = 1'b1;
    bit          exp_mrdy = 1'b1;
    bit          exp_wr = 1'b0;
    bit          exp_err = 1'b0;
    logic [15:0] exp_cnt = 16'd0;
    bit          active = 1'b0;
    int          age = 0;
    logic [15:0] c_addr;
    bit          c_rnw, c_slow;
    logic [7:0]  c_dout;
    bit          qp = 1'b0, ep = 1'b0;

    always @(posedge clk) begin : model
        bit qr, ef;
        qr = Q && !qp;
        ef = !E && ep;
        qp = Q;
        ep = E;
        if (reset) begin
            exp_d = 8'h12; exp_d_known = 1'b1; exp_mrdy = 1'b1; exp_wr = 1'b0;
            exp_err = 1'b0; exp_cnt = 16'd0; active = 1'b0;
        end else begin
            exp_wr = 1'b0;
            if (active) begin
                age++;
                if (age == 1 && c_rnw) begin
                    if (c_addr < 16'h1000) begin
                        exp_d = mem_m[c_addr[11:0]];
                        exp_d_known = known_m[c_addr[11:0]];
                    end else if (c_addr >= 16'hFFF0) begin
                        exp_d = c_addr[0] ? RV[7:0] : RV[15:8];
                        exp_d_known = 1'b1;
                    end else begin
                        exp_d = 8'h12;
                        exp_d_known = 1'b1;
                    end
                end
                if (c_slow)
                    exp_mrdy = !(age >= 1 && age <= W);
                if (age >= (c_slow ? W + 2 : 2)) begin
                    if (ef) begin
                        if (!c_rnw && c_addr < 16'h1000) begin
                            mem_m[c_addr[11:0]] = c_dout;
                            known_m[c_addr[11:0]] = 1'b1;
                            exp_wr = 1'b1;
                        end
                        active = 1'b0;
                    end else if (qr) begin
                        exp_err = 1'b1;
                        active = 1'b0;
                    end
                end
            end
            if (!active && qr && !BA) begin
                c_addr = ADDR; c_rnw = RnW; c_dout = DOut;
                c_slow = ((ADDR & 16'hF000) == 16'h8000);
                exp_cnt = exp_cnt + 16'd1;
                active = 1'b1;
                age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("MRDY", 16'(MRDY), 16'(exp_mrdy));
            chk("wr_strobe", 16'(wr_strobe), 16'(exp_wr));
            chk("bus_cycles", bus_cycles, exp_cnt);
            chk("bus_err", 16'(bus_err), 16'(exp_err));
            if (exp_d_known)
                chk("D", 16'(D), 16'(exp_d));
            if (!MRDY) low_cnt++;
            if (wr_strobe) wr_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    bit pend_efall = 1'b0;

    // shape 0: normal; 1: E falls together with the next Q rise; 2: E still high at next Q rise.
    task automatic bus_cyc(input logic [15:0] a, input bit rnw, input logic [7:0] dv,
                           input bit ba, input int shape);
        ADDR = a; RnW = rnw; DOut = dv; BA = ba; Q = 1'b1;
        if (pend_efall) begin
            E = 1'b0;
            pend_efall = 1'b0;
        end
        tick(1);
        ADDR = 16'($urandom);
        DOut = 8'($urandom);
        tick(3); E = 1'b1;
        tick(4); Q = 1'b0;
        tick(4);
        if (shape == 0) begin
            E = 1'b0;
            tick(4);
        end else if (shape == 1) begin
            pend_efall = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [15:0] pool [8] = '{16'h0000, 16'h0001, 16'h0123, 16'h0FFF,
                              16'h0800, 16'h0456, 16'h0ABC, 16'h0010};

    initial begin
        int lc0, wc0, sel, r;
        logic [15:0] a;
        tick(1);
        checking = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("reset D", 16'(D), 16'h0012);
        chk("reset MRDY", 16'(MRDY), 16'h0001);
        chk("reset wr_strobe", 16'(wr_strobe), 16'h0000);
        chk("reset bus_cycles", bus_cycles, 16'h0000);
        chk("reset bus_err", 16'(bus_err), 16'h0000);

        for (int i = 0; i < 4; i++)
            bus_cyc(16'h4000 + 16'(i), 1'b1, 8'h00, 1'b0, 0);
        chk("nop D", 16'(D), 16'h0012);
        chk("nop bus_cycles", bus_cycles, 16'd4);

        bus_cyc(16'hFFFE, 1'b1, 8'h00, 1'b0, 0);
        chk("vec FFFE", 16'(D), 16'h00E0);
        bus_cyc(16'hFFFF, 1'b1, 8'h00, 1'b0, 0);
        chk("vec FFFF", 16'(D), 16'h0000);

        wc0 = wr_cnt;
        bus_cyc(16'h0123, 1'b0, 8'h5A, 1'b0, 0);
        chk("ram wr pulses", 16'(wr_cnt - wc0), 16'd1);
        bus_cyc(16'h0123, 1'b1, 8'h00, 1'b0, 0);
        chk("ram rd 0123", 16'(D), 16'h005A);

        wc0 = wr_cnt;
        bus_cyc(16'h9000, 1'b0, 8'h77, 1'b0, 0);
        chk("unmapped wr pulses", 16'(wr_cnt - wc0), 16'd0);
        bus_cyc(16'h9000, 1'b1, 8'h00, 1'b0, 0);
        chk("unmapped rd 9000", 16'(D), 16'h0012);

        lc0 = low_cnt;
        bus_cyc(16'h8004, 1'b1, 8'h00, 1'b0, 0);
        chk("slow low clks", 16'(low_cnt - lc0), 16'd4);
        lc0 = low_cnt;
        bus_cyc(16'h7004, 1'b1, 8'h00, 1'b0, 0);
        chk("fast low clks", 16'(low_cnt - lc0), 16'd0);

        bus_cyc(16'h0123, 1'b1, 8'h00, 1'b1, 0);
        chk("BA bus_cycles", bus_cycles, 16'd12);
        chk("BA D", 16'(D), 16'h0012);

        bus_cyc(16'h0123, 1'b0, 8'h33, 1'b0, 0);
        bus_cyc(16'h0123, 1'b0, 8'h99, 1'b0, 2);
        bus_cyc(16'h0123, 1'b1, 8'h00, 1'b0, 0);
        chk("abort D", 16'(D), 16'h0033);
        chk("abort bus_err", 16'(bus_err), 16'h0001);
        chk("abort bus_cycles", bus_cycles, 16'd15);

        ADDR = 16'h8004; RnW = 1'b1; BA = 1'b0; Q = 1'b1;
        tick(3);
        chk("pre-reset MRDY low", 16'(MRDY), 16'h0000);
        reset = 1'b1;
        tick(1);
        chk("wait reset MRDY", 16'(MRDY), 16'h0001);
        chk("wait reset bus_cycles", bus_cycles, 16'd0);
        chk("wait reset wr_strobe", 16'(wr_strobe), 16'h0000);
        reset = 1'b0;
        tick(2); E = 1'b1;
        tick(4); Q = 1'b0;
        tick(4); E = 1'b0;
        tick(4);
        chk("post-reset bus_cycles", bus_cycles, 16'd0);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0, 1:    a = pool[$urandom_range(0, 7)];
                2:       a = 16'hFFF0 | 16'($urandom_range(0, 15));
                3:       a = 16'h8000 | 16'($urandom_range(0, 4095));
                4:       a = 16'h7000 | 16'($urandom_range(0, 4095));
                5:       a = 16'($urandom);
                6:       a = 16'($urandom_range(0, 4095));
                default: a = 16'h9000 | 16'($urandom_range(0, 4095));
            endcase
            r = $urandom_range(0, 19);
            bus_cyc(a, 1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 9) == 0), (r < 3) ? 1 : ((r < 5) ? 2 : 0));
        end
        E = 1'b0;
        pend_efall = 1'b0;
        tick(8);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
